cdc_hs_tx_fifo: RTL and testbench
=================================

// Module: cdc_hs_tx_fifo
// PURPOSE
//  Parametrised source side of a 4-phase req/ack handshake, entirely in the sclk domain.
//  Buffers words in a small FIFO and presents each on a held-stable data bus with req_out.
//  Brings the remote ack_in in through an N-stage synchroniser.
//  Adds FIFO depth, a stuck-ack timeout and a sent-word counter for back-to-back transfers.
// PARAMETERS
//  DATA_W       6    width of each transferred word
//  FIFO_DEPTH   4    FIFO entries; power of 2, >=2
//  SYNC_STAGES  2    flops in the ack_in synchroniser; >=2
//  ACK_TIMEOUT  255  max sclk cycles in REQ or DROP before abort; 0 disables the timeout
// PORTS
//  sclk         in   1                       single clock; all logic on its rising edge
//  rst_n        in   1                       asynchronous, active-low reset
//  in_valid     in   1                       producer presents in_data
//  in_ready     out  1                       FIFO can accept; = !full
//  in_data      in   DATA_W                  word to send
//  req_out      out  1                       handshake request to the remote domain, registered
//  data_out     out  DATA_W                  word under transfer, registered, held stable
//  ack_in       in   1                       remote acknowledge; asynchronous, synchronised internally
//  busy         out  1                       FSM not IDLE, or FIFO not empty
//  fifo_level   out  $clog2(FIFO_DEPTH)+1    entries currently in the FIFO
//  sent_cnt     out  16                      completed transfers; wraps modulo 2^16
//  timeout_err  out  1                       sticky; set when a handshake is aborted
//  err_clr      in   1                       clears timeout_err
// BEHAVIOUR
//  Reset, asynchronous: applies immediately, mid-transfer included; the in-flight word is lost.
//   - req_out=0, data_out=0, fifo_level=0, sent_cnt=0, timeout_err=0, busy=0, in_ready=1.
//   - Synchroniser flops cleared to 0; FSM enters IDLE.
//  FIFO
//   - Push when in_valid && in_ready.
//   - Pop only by the FSM when it loads a word.
//   - Push and pop in the same cycle: both take effect; level unchanged.
//   - Full: in_ready=0 even if a pop occurs that cycle; no bypass.
//   - No fall-through: a word pushed at edge E0 is loadable at the earliest at edge E1.
//  ack_s = ack_in after SYNC_STAGES flops.
//  FSM states: IDLE, REQ, DROP.
//   - IDLE: if FIFO non-empty && ack_s==0 -> pop head into data_out, req_out<=1, go REQ.
//       If ack_s is still 1, wait in IDLE.
//   - REQ: if ack_s==1 -> req_out<=0, go DROP. data_out held unchanged.
//   - DROP: if ack_s==0 -> sent_cnt<=sent_cnt+1, go IDLE. data_out held until the next load.
//  Latency: word accepted into an empty FIFO at edge E0 -> req_out=1 and data_out valid after E1.
//  Timeout counter
//   - Cleared on entry to REQ and on entry to DROP; increments each cycle in REQ or DROP.
//   - When it reaches ACK_TIMEOUT: req_out<=0, timeout_err<=1, go IDLE.
//   - The aborted word is not counted in sent_cnt and is not retried.
//   - A new req is not raised until ack_s==0.
//  err_clr: clears timeout_err next edge. A set and err_clr in the same cycle: set wins.
//  data_out changes only on the IDLE->REQ load edge, so it is stable whenever req_out=1.
// STRUCTURE
//  Shared package cdc_pkg:
//   - FSM encoding: IDLE=2'd0, REQ=2'd1, DROP=2'd2.
//   - SENT_CNT_W=16.
//   - A function returning the timeout counter width, $clog2(ACK_TIMEOUT+1).
//  Sub-module sync_bit #(STAGES): reset-to-0 flop chain for ack_in; reused by the future rx side.
//  FIFO storage, pointers, FSM and counters stay inline in this module.
// TESTING
//  Bench responder model: raises ack 3 cycles after seeing req, drops it 3 cycles after req falls.
//  1. Reset then push 6'h15 -> req_out=1 one edge after acceptance, data_out=6'h15.
//     Then req falls, and sent_cnt=1 after ack returns low.
//  2. Push 6'h01..6'h04 back-to-back -> in_ready=0 only while fifo_level=4.
//     Outputs 01,02,03,04 in order, one req per word; sent_cnt=4; busy falls after the last DROP.
//  3. Responder never acks, ACK_TIMEOUT=8 -> req_out drops 8 cycles after entering REQ.
//     timeout_err=1, sent_cnt unchanged, the next FIFO word is sent normally.
//  4. ack_in held high after a timeout -> no new req until ack_in is low for SYNC_STAGES+1 cycles.
//     err_clr together with a new timeout keeps timeout_err=1.
//  5. rst_n pulsed low in REQ with 3 words queued -> req_out=0 immediately, fifo_level=0.
//     Clean restart with a new word 6'h2A.
//  6. Preload sent_cnt to 16'hFFFF via transfers, one more transfer -> sent_cnt=16'h0000.
//     Also push and pop in the same cycle at level 2 -> level stays 2.

Source files
------------

// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types and constants for the cdc handshake blocks
//
// Purpose : FSM state encoding, sent-word counter width and a helper that
//           sizes the stuck-ack timeout counter.
// Ports   : none (package).

package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } hs_state_e;

    localparam int SENT_CNT_W = 16;

    // Width of a counter able to hold 0..ack_timeout. A disabled timeout (0)
    // still gets one bit so the counter stays declarable.
    function automatic int tmo_cnt_w(input int ack_timeout);
        return (ack_timeout < 1) ? 1 : $clog2(ack_timeout + 1);
    endfunction

endpackage

// File: rtl/cdc_hs_tx_fifo_if.sv
// rtl/cdc_hs_tx_fifo_if.sv - producer and 4-phase handshake signals of the tx side
//
// Purpose : bundles the producer-side word interface and the req/ack/data
//           handshake towards the remote domain.
// Signals : in_valid/in_ready/in_data - producer word handshake
//           req_out/data_out           - request and held-stable word to remote
//           ack_in                     - asynchronous remote acknowledge
// Modports: slave  - the tx block (drives in_ready, req_out, data_out)
//           master - producer plus remote responder (drives the rest)

interface cdc_hs_tx_fifo_if #(
    parameter int DATA_W = 6
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              req_out;
    logic [DATA_W-1:0] data_out;
    logic              ack_in;

    modport slave (
        input  in_valid,
        input  in_data,
        input  ack_in,
        output in_ready,
        output req_out,
        output data_out
    );

    modport master (
        output in_valid,
        output in_data,
        output ack_in,
        input  in_ready,
        input  req_out,
        input  data_out
    );

endinterface

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - reset-to-0 flop chain synchronising one asynchronous bit
//
// Purpose : brings a single asynchronous level into the sclk domain.
// Params  : STAGES - number of flops in the chain, >= 2
// Ports   : sclk  in  sampling clock
//           rst_n in  asynchronous active-low reset, clears the chain to 0
//           d     in  asynchronous input bit
//           q     out synchronised bit, STAGES edges after d settles

module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_hs_tx_fifo.sv
// rtl/cdc_hs_tx_fifo.sv - FIFO-buffered source side of a 4-phase req/ack handshake
//
// Purpose : buffers producer words in a small FIFO and sends each one to the
//           remote domain over a 4-phase req/ack handshake, data held stable
//           while req_out is high. ack_in is synchronised internally. A stuck
//           ack aborts the handshake after ACK_TIMEOUT cycles in REQ or DROP.
// Params  : DATA_W      word width
//           FIFO_DEPTH  FIFO entries, power of 2, >= 2
//           SYNC_STAGES flops in the ack_in synchroniser, >= 2
//           ACK_TIMEOUT cycles in REQ/DROP before abort, 0 disables
// Ports   : sclk        in  single clock, rising edge
//           rst_n       in  asynchronous active-low reset
//           bus         if  slave side of cdc_hs_tx_fifo_if (in_valid, in_ready,
//                           in_data, req_out, data_out, ack_in)
//           busy        out FSM not IDLE or FIFO not empty
//           fifo_level  out entries currently in the FIFO
//           sent_cnt    out completed transfers, wraps modulo 2^16
//           timeout_err out sticky abort flag
//           err_clr     in  clears timeout_err (a same-cycle set wins)

module cdc_hs_tx_fifo
    import cdc_pkg::*;
#(
    parameter int DATA_W      = 6,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                          sclk,
    input  logic                          rst_n,
    cdc_hs_tx_fifo_if.slave               bus,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [SENT_CNT_W-1:0]         sent_cnt,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = tmo_cnt_w(ACK_TIMEOUT);

    // FIFO storage and pointers. Pointers carry one extra wrap bit so that
    // full and empty are distinguishable by their difference alone.
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       level;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    logic              ack_s;
    hs_state_e         state;
    logic [TW-1:0]     tmo_cnt;
    logic              tmo_hit;
    logic              req_q;
    logic [DATA_W-1:0] data_q;
    logic [SENT_CNT_W-1:0] sent_cnt_q;
    logic              err_q;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW+1)'(FIFO_DEPTH));
    assign empty = (level == '0);

    // in_ready depends only on the registered level, so a pop in the same
    // cycle never opens a slot early.
    assign push = bus.in_valid && !full;

    // A load needs the remote side back at ack=0, which also keeps a fresh
    // request from being raised while a stale ack lingers after an abort.
    assign pop  = (state == IDLE) && !empty && !ack_s;

    // The abort fires on the edge where the count would reach ACK_TIMEOUT,
    // i.e. ACK_TIMEOUT edges after entering REQ or DROP.
    assign tmo_hit = (ACK_TIMEOUT != 0) && (tmo_cnt == TW'(ACK_TIMEOUT - 1));

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .sclk  (sclk),
        .rst_n (rst_n),
        .d     (bus.ack_in),
        .q     (ack_s)
    );

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage has no reset: contents are only visible after a push.
    always_ff @(posedge sclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            data_q     <= '0;
            tmo_cnt    <= '0;
            sent_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            // Any abort below overrides this clear in the same cycle.
            if (err_clr) begin
                err_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        data_q  <= mem[rd_ptr[AW-1:0]];
                        req_q   <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= REQ;
                    end
                end

                REQ: begin
                    if (ack_s) begin
                        req_q   <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= DROP;
                    end else if (tmo_hit) begin
                        req_q <= 1'b0;
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                DROP: begin
                    if (!ack_s) begin
                        sent_cnt_q <= sent_cnt_q + SENT_CNT_W'(1);
                        state      <= IDLE;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                default: begin
                    req_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = !full;
    assign bus.req_out  = req_q;
    assign bus.data_out = data_q;
    assign busy         = (state != IDLE) || !empty;
    assign fifo_level   = level;
    assign sent_cnt     = sent_cnt_q;
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_cdc_hs_tx_fifo.sv
// tb/tb_cdc_hs_tx_fifo.sv - scoreboard bench for cdc_hs_tx_fifo

module tb_cdc_hs_tx_fifo;

    localparam int DATA_W      = 6;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int ACK_TIMEOUT = 8;

    logic        sclk;
    logic        rst_n;
    logic        busy;
    logic [2:0]  fifo_level;
    logic [15:0] sent_cnt;
    logic        timeout_err;
    logic        err_clr;

    cdc_hs_tx_fifo_if #(.DATA_W(DATA_W)) bus ();

    cdc_hs_tx_fifo #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .sclk        (sclk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .sent_cnt    (sent_cnt),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [5:0] exp_q [$];

    // 0: normal responder, 1: never acks, 2: ack_in follows ack_force
    int   resp_mode = 0;
    logic ack_force = 1'b0;
    int   resp_cnt  = 0;

    logic       mon_prev_req = 1'b0;
    logic [5:0] mon_cur      = '0;

    int k;
    int hi;
    logic [5:0] w2 [4] = '{6'h01, 6'h02, 6'h03, 6'h04};

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_word(input logic [5:0] w, input string name);
        int   g;
        logic acc;
        g   = 0;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        while (!acc && g < 100) begin
            acc = bus.in_ready;
            tick(1);
            g++;
        end
        bus.in_valid = 1'b0;
        if (acc) exp_q.push_back(w);
        else fail_bound(name);
    endtask

    task automatic wait_sent(input logic [15:0] target, input string name);
        int g;
        g = 0;
        while (sent_cnt !== target && g < 200) begin
            tick(1);
            g++;
        end
        check(name, sent_cnt, target);
    endtask

    // Remote responder: ack 3 cycles after seeing req, drop 3 cycles after req falls.
    initial begin
        bus.ack_in = 1'b0;
        forever begin
            @(posedge sclk);
            #2;
            if (resp_mode == 0) begin
                if (bus.req_out && !bus.ack_in) begin
                    resp_cnt++;
                    if (resp_cnt == 3) begin
                        bus.ack_in = 1'b1;
                        resp_cnt   = 0;
                    end
                end else if (!bus.req_out && bus.ack_in) begin
                    resp_cnt++;
                    if (resp_cnt == 3) begin
                        bus.ack_in = 1'b0;
                        resp_cnt   = 0;
                    end
                end else begin
                    resp_cnt = 0;
                end
            end else if (resp_mode == 1) begin
                resp_cnt = 0;
            end else begin
                resp_cnt   = 0;
                bus.ack_in = ack_force;
            end
        end
    end

    // Monitor: every new request must carry the next scoreboard word, and the
    // word must stay put for as long as req_out is high.
    initial begin
        forever begin
            @(negedge sclk);
            if (!rst_n) begin
                mon_prev_req = 1'b0;
            end else begin
                if (bus.req_out && !mon_prev_req) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL mon_unexpected_req: data_out 0x%0h with empty scoreboard", bus.data_out);
                    end else begin
                        mon_cur = exp_q.pop_front();
                        check("mon_word", bus.data_out, mon_cur);
                    end
                end else if (bus.req_out) begin
                    check("mon_stable", bus.data_out, mon_cur);
                end
                mon_prev_req = bus.req_out;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        err_clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset values
        #12;
        check("rst_req_out", bus.req_out, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_sent_cnt", sent_cnt, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(negedge sclk);
        rst_n = 1'b1;
        tick(1);

        // 1: single word, latency and completion
        push_word(6'h15, "t1_push");
        check("t1_req_not_yet", bus.req_out, 0);
        check("t1_level_after_push", fifo_level, 1);
        check("t1_busy", busy, 1);
        tick(1);
        check("t1_req_rise", bus.req_out, 1);
        check("t1_data_out", bus.data_out, 6'h15);
        check("t1_level_after_load", fifo_level, 0);
        k = 0;
        while (bus.req_out && k < 30) begin tick(1); k++; end
        check("t1_req_fell", bus.req_out, 0);
        check("t1_sent_before_ack_low", sent_cnt, 0);
        wait_sent(16'd1, "t1_sent_cnt");
        check("t1_busy_done", busy, 0);

        // 2: fill to full while ack is held high, then drain in order
        resp_mode = 2;
        ack_force = 1'b1;
        tick(3);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_in_ready_before_%0d", i), bus.in_ready, 1);
            push_word(w2[i], "t2_push");
            check($sformatf("t2_level_%0d", i), fifo_level, i + 1);
        end
        check("t2_in_ready_full", bus.in_ready, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 6'h3F;
        tick(2);
        bus.in_valid = 1'b0;
        check("t2_level_full_hold", fifo_level, 4);
        check("t2_no_req_while_ack", bus.req_out, 0);
        ack_force = 1'b0;
        tick(1);
        resp_mode = 0;
        check("t2_busy_draining", busy, 1);
        wait_sent(16'd5, "t2_sent_cnt");
        check("t2_busy_done", busy, 0);
        check("t2_level_empty", fifo_level, 0);
        check("t2_in_ready_empty", bus.in_ready, 1);

        // 3: never-acking responder -> abort after ACK_TIMEOUT cycles
        resp_mode = 1;
        push_word(6'h11, "t3_push_11");
        push_word(6'h22, "t3_push_22");
        k = 0;
        @(negedge sclk);
        while (!bus.req_out && k < 20) begin @(negedge sclk); k++; end
        hi = 0;
        while (bus.req_out && hi < 40) begin hi++; @(negedge sclk); end
        resp_mode = 0;
        check("t3_req_high_cycles", hi, 8);
        check("t3_timeout_err", timeout_err, 1);
        check("t3_sent_unchanged", sent_cnt, 5);
        tick(1);
        wait_sent(16'd6, "t3_next_word_sent");
        check("t3_err_sticky", timeout_err, 1);

        // 4: DROP timeout with ack stuck high, err_clr racing the set
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t4_err_cleared", timeout_err, 0);
        resp_mode = 2;
        ack_force = 1'b0;
        push_word(6'h33, "t4_push_33");
        push_word(6'h0C, "t4_push_0c");
        tick(2);
        ack_force = 1'b1;
        k = 0;
        while (bus.req_out && k < 30) begin tick(1); k++; end
        check("t4_req_fell", bus.req_out, 0);
        tick(6);
        check("t4_no_early_abort", timeout_err, 0);
        err_clr = 1'b1;
        tick(2);
        err_clr = 1'b0;
        check("t4_set_beats_clr", timeout_err, 1);
        check("t4_sent_unchanged", sent_cnt, 6);
        tick(4);
        check("t4_no_req_ack_high", bus.req_out, 0);
        check("t4_word_waiting", fifo_level, 1);
        ack_force = 1'b0;
        tick(2);
        check("t4_no_req_sync_delay", bus.req_out, 0);
        tick(1);
        check("t4_req_after_sync", bus.req_out, 1);
        check("t4_data_0c", bus.data_out, 6'h0C);
        resp_mode = 0;
        wait_sent(16'd7, "t4_sent_cnt");
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t4_err_cleared_end", timeout_err, 0);

        // 5: asynchronous reset in REQ with 3 words queued
        push_word(6'h3A, "t5_push_3a");
        push_word(6'h3B, "t5_push_3b");
        push_word(6'h3C, "t5_push_3c");
        push_word(6'h3D, "t5_push_3d");
        check("t5_level_queued", fifo_level, 3);
        check("t5_in_req", bus.req_out, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_req_out", bus.req_out, 0);
        check("t5_rst_level", fifo_level, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_in_ready", bus.in_ready, 1);
        check("t5_rst_sent_cnt", sent_cnt, 0);
        check("t5_rst_data_out", bus.data_out, 0);
        exp_q.delete();
        @(negedge sclk);
        rst_n = 1'b1;
        tick(6);
        push_word(6'h2A, "t5_push_2a");
        check("t5_req_not_yet", bus.req_out, 0);
        tick(1);
        check("t5_req_rise", bus.req_out, 1);
        check("t5_data_2a", bus.data_out, 6'h2A);
        wait_sent(16'd1, "t5_sent_cnt");

        // 6: counter wrap and simultaneous push/pop at level 2
        resp_mode = 2;
        ack_force = 1'b1;
        tick(3);
        force dut.sent_cnt_q = 16'hFFFD;
        tick(1);
        release dut.sent_cnt_q;
        check("t6_preload", sent_cnt, 16'hFFFD);
        push_word(6'h10, "t6_push_10");
        push_word(6'h20, "t6_push_20");
        check("t6_level_2", fifo_level, 2);
        ack_force = 1'b0;
        tick(2);
        push_word(6'h30, "t6_push_30");
        check("t6_level_push_pop", fifo_level, 2);
        check("t6_req_load", bus.req_out, 1);
        check("t6_data_10", bus.data_out, 6'h10);
        resp_mode = 0;
        wait_sent(16'hFFFE, "t6_sent_fffe");
        wait_sent(16'hFFFF, "t6_sent_ffff");
        wait_sent(16'h0000, "t6_sent_wrap");
        check("t6_busy_done", busy, 0);
        check("t6_level_empty", fifo_level, 0);

        tick(2);
        check("end_scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
